// File: rtl/hamming74_rx_decoder_if.sv
// Frame-in / nibble-out handshake between the UART receiver, the Hamming decoder and its consumer.
interface hamming74_rx_decoder_if;
    logic [6:0] in_data;
    logic       in_valid;
    logic [3:0] out_data;
    logic       out_corrected;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_corrected, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_corrected, out_valid
    );
endinterface

// File: rtl/hamming74_rx_decoder.sv
// Hamming(7,4) single-error-correcting decoder: one register stage, then a small
// ready/valid FIFO, plus corrected-frame and overflow statistics.
module hamming74_rx_decoder #(
    parameter  int DEPTH  = 4,
    parameter  int CNT_W  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 clr_stats,
    hamming74_rx_decoder_if.slave bus,
    output logic [ADDR_W:0]      fifo_count,
    output logic [CNT_W-1:0]     corr_count,
    output logic                 overflow
);
    typedef struct packed {
        logic       corrected;
        logic [3:0] nibble;
    } entry_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [6:0]        cw_q;
    logic              v1;
    logic [2:0]        syn;
    logic [6:0]        cw_fix;
    entry_t            dec;
    entry_t            mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic              full, pop, push, drop;

    // Syndrome value S names the 1-based position of the flipped bit.
    always_comb begin
        syn    = {cw_q[3] ^ cw_q[4] ^ cw_q[5] ^ cw_q[6],
                  cw_q[1] ^ cw_q[2] ^ cw_q[5] ^ cw_q[6],
                  cw_q[0] ^ cw_q[2] ^ cw_q[4] ^ cw_q[6]};
        cw_fix = cw_q ^ ((syn != 3'd0) ? (7'd1 << (syn - 3'd1)) : 7'd0);
        dec    = '{corrected: (syn != 3'd0),
                   nibble:    {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]}};
    end

    assign full          = (fifo_count == FULL_CNT);
    assign bus.out_valid = (fifo_count != '0);
    assign pop           = bus.out_valid & bus.out_ready;
    assign push          = v1 & (~full | pop);
    assign drop          = v1 & full & ~pop;

    assign bus.out_data      = mem[rd_ptr].nibble;
    assign bus.out_corrected = mem[rd_ptr].corrected;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_q <= '0;
            v1   <= 1'b0;
        end else if (ena) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) cw_q <= bus.in_data;
        end
    end

    // Storage is reset too so the head outputs read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (ena) begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_count <= '0;
            overflow   <= 1'b0;
        end else if (ena) begin
            if (clr_stats) begin
                corr_count <= '0;
                overflow   <= 1'b0;
            end else begin
                if (push && dec.corrected && (corr_count != '1))
                    corr_count <= corr_count + 1'b1;
                if (drop) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hamming74_rx_decoder.sv
// Directed bench for hamming74_rx_decoder: inputs driven and outputs sampled on the falling edge.
module tb_hamming74_rx_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       clr_stats = 1'b0;
    logic [2:0] fifo_count;
    logic [7:0] corr_count;
    logic       overflow;
    int         checks = 0;
    int         errors = 0;

    hamming74_rx_decoder_if bus ();

    hamming74_rx_decoder #(.DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .clr_stats  (clr_stats),
        .bus        (bus),
        .fifo_count (fifo_count),
        .corr_count (corr_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Valid codewords and their nibbles, encoded by hand.
    logic [6:0] cw_tab  [8] = '{7'h55, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h7F, 7'h00};
    logic [3:0] nib_tab [8] = '{4'hB,  4'h1,  4'h2,  4'h3,  4'h4,  4'h5,  4'hF,  4'h0};

    task automatic send(input logic [6:0] cw);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = cw;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic clear_stats();
        @(negedge clk);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.out_valid, fifo_count, corr_count, overflow, bus.out_data, bus.out_corrected} !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b cnt=%0d corr=%0d ovf=%b data=%h got, all zero expected",
                     bus.out_valid, fifo_count, corr_count, overflow, bus.out_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean();
        send(7'h55);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL no_bypass: out_valid=%b expected 0", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_corrected, corr_count} !== {1'b1, 4'hB, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL clean: v=%b d=%h c=%b corr=%0d expected 1 b 0 0",
                     bus.out_valid, bus.out_data, bus.out_corrected, corr_count);
        end
        pop_one();
    endtask

    task automatic test_single_error();
        send(7'h45);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_corrected, corr_count} !== {1'b1, 4'hB, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL single_err: v=%b d=%h c=%b corr=%0d expected 1 b 1 1",
                     bus.out_valid, bus.out_data, bus.out_corrected, corr_count);
        end
        pop_one();
        for (int i = 0; i < 7; i++) begin
            logic [6:0] cw;
            cw = 7'h7F;
            cw[i] = 1'b0;
            send(cw);
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_corrected} !== {1'b1, 4'hF, 1'b1}) begin
                errors++;
                $display("FAIL flip_sweep bit%0d: v=%b d=%h c=%b expected 1 f 1",
                         i, bus.out_valid, bus.out_data, bus.out_corrected);
            end
            pop_one();
        end
        checks++;
        if (corr_count !== 8'd8) begin
            errors++; $display("FAIL sweep_count: corr=%0d expected 8", corr_count);
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 7'h00;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({fifo_count, overflow} !== {3'd4, 1'b1}) begin
            errors++; $display("FAIL overflow: cnt=%0d ovf=%b expected 4 1", fifo_count, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, 4'h0}) begin
                errors++; $display("FAIL drain%0d: v=%b d=%h expected 1 0", i, bus.out_valid, bus.out_data);
            end
            pop_one();
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL drained: out_valid=%b expected 0", bus.out_valid);
        end
        clear_stats();
        checks++;
        if ({overflow, corr_count} !== 9'd0) begin
            errors++; $display("FAIL clr_stats: ovf=%b corr=%0d expected 0 0", overflow, corr_count);
        end
    endtask

    task automatic test_full_simultaneous();
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = cw_tab[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++; $display("FAIL fill: cnt=%0d expected 4", fifo_count);
        end
        // Frame 5 reaches the FIFO on the same edge the head is popped.
        bus.in_valid = 1'b1; bus.in_data = cw_tab[5];
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if ({fifo_count, overflow} !== {3'd4, 1'b0}) begin
            errors++; $display("FAIL full_simul: cnt=%0d ovf=%b expected 4 0", fifo_count, overflow);
        end
        for (int i = 2; i <= 5; i++) begin
            checks++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, nib_tab[i]}) begin
                errors++;
                $display("FAIL order%0d: v=%b d=%h expected 1 %h", i, bus.out_valid, bus.out_data, nib_tab[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_wrap_saturation();
        int bad = 0;
        clear_stats();
        bus.out_ready = 1'b1;
        // Frame k is pushed one edge after capture and is the head at the negedge k+2.
        for (int k = 0; k < 302; k++) begin
            if (k >= 2) begin
                if ({bus.out_valid, bus.out_data, bus.out_corrected} !== {1'b1, nib_tab[(k-2)%8], 1'b1})
                    bad++;
            end
            if (k < 300) begin
                logic [6:0] cw;
                cw = cw_tab[k%8];
                cw[k%7] = ~cw[k%7];
                bus.in_valid = 1'b1; bus.in_data = cw;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL wrap_order: %0d bad heads, expected 0", bad);
        end
        checks++;
        if ({corr_count, bus.out_valid} !== {8'hFF, 1'b0}) begin
            errors++; $display("FAIL saturate: corr=%h v=%b expected ff 0", corr_count, bus.out_valid);
        end
        clear_stats();
        checks++;
        if (corr_count !== 8'd0) begin
            errors++; $display("FAIL sat_clear: corr=%h expected 00", corr_count);
        end
    endtask

    task automatic test_ena_reset();
        ena = 1'b0;
        send(7'h55);
        repeat (2) @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, fifo_count} !== 4'd0) begin
            errors++; $display("FAIL ena_drop: v=%b cnt=%0d expected 0 0", bus.out_valid, fifo_count);
        end
        send(7'h07);
        send(7'h19);
        @(negedge clk);
        ena = 1'b0;
        pop_one();
        ena = 1'b1;
        checks++;
        if ({fifo_count, bus.out_data} !== {3'd2, 4'h1}) begin
            errors++; $display("FAIL ena_pop: cnt=%0d d=%h expected 2 1", fifo_count, bus.out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, fifo_count, overflow} !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: v=%b cnt=%0d ovf=%b expected 0 0 0", bus.out_valid, fifo_count, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Frame in stage 1 at reset is discarded.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 7'h55;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_midframe: out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_error();
        test_overflow();
        test_full_simultaneous();
        test_wrap_saturation();
        test_ena_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
